// File: rtl/spi_flash_rd.sv
// Read-only picorv32 memory-bus responder that fetches words from SPI flash with READ (0x03), SPI mode 0.
// Define SPI_FLASH_SEQ_EN to keep CS low after a read and stream the next sequential word without CMD/ADDR.
module spi_flash_rd #(
  parameter int DIV     = 2,
  parameter int CS_HIGH = 8
) (
  input  logic        CLK100MHZ,
  input  logic        resetn,
  input  logic        sel,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy
);

`ifdef SPI_FLASH_SEQ_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE, GAP, HOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE, GAP} state_t;
`endif

  localparam logic [7:0]  DIV_M1 = 8'(DIV - 1);
  localparam logic [15:0] GAP_M1 = 16'(CS_HIGH - 1);

  state_t      state, state_next;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] gap_cnt;
  logic        armed;
  logic        live;
  logic [31:0] shreg;
  logic [31:0] rx;
  logic        rd_req, wr_req, in_shift, tick, rise, fall, last_bit;
  logic [4:0]  rx_idx;
  logic        unused_addr;

  // A ready pulse in the previous cycle blocks acceptance while the CPU drops mem_valid.
  assign rd_req   = mem_valid & sel & ~mem_ready & (mem_wstrb == 4'b0000);
  assign wr_req   = mem_valid & sel & ~mem_ready & (mem_wstrb != 4'b0000);
  assign in_shift = (state == CMD) | (state == ADDR) | (state == DATA);
  assign tick     = in_shift & armed & (div_cnt == DIV_M1);
  assign rise     = tick & ~spi_sck;
  assign fall     = tick & spi_sck;
  // Bytes arrive MSB first; byte k lands in bits [8k+7:8k].
  assign rx_idx   = {bit_cnt[4:3], ~bit_cnt[2:0]};
  assign busy     = (state != IDLE);
  assign unused_addr = &{1'b0, mem_addr[31:24], mem_addr[1:0]};

`ifdef SPI_FLASH_SEQ_EN
  logic [21:0] next_word;
  logic        seq_hit;
  assign seq_hit = (mem_addr[23:2] == next_word);
`endif

  always_comb begin
    state_next = state;
    last_bit   = 1'b0;
    case (state)
      IDLE: if (rd_req) state_next = CMD;
      CMD: begin
        last_bit = (bit_cnt == 5'd7);
        if (fall && last_bit) state_next = ADDR;
      end
      ADDR: begin
        last_bit = (bit_cnt == 5'd23);
        if (fall && last_bit) state_next = DATA;
      end
      DATA: begin
        last_bit = (bit_cnt == 5'd31);
        if (fall && last_bit) state_next = DONE;
      end
`ifdef SPI_FLASH_SEQ_EN
      DONE: state_next = HOLD;
      HOLD: begin
        if (rd_req && seq_hit) state_next = DATA;
        else if (rd_req || wr_req) state_next = GAP;
      end
`else
      DONE: state_next = GAP;
`endif
      GAP: if (gap_cnt == GAP_M1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!resetn) begin
      spi_csn   <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      armed     <= 1'b0;
      live      <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      mem_ready <= 1'b0;
      live      <= live & mem_valid;
      if (in_shift) begin
        // First cycle of a shift burst only lowers CS and presents the first bit.
        if (!armed) begin
          armed    <= 1'b1;
          spi_csn  <= 1'b0;
          spi_mosi <= (state == DATA) ? 1'b0 : shreg[31];
          div_cnt  <= '0;
        end else if (div_cnt == DIV_M1) begin
          div_cnt <= '0;
          spi_sck <= ~spi_sck;
          if (spi_sck) begin
            spi_mosi <= shreg[30];
            bit_cnt  <= last_bit ? 5'd0 : bit_cnt + 5'd1;
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end else begin
        armed <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (wr_req) mem_ready <= 1'b1;
          if (rd_req) begin
            live    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        DONE: begin
          mem_ready <= live & mem_valid;
          mem_rdata <= rx;
`ifndef SPI_FLASH_SEQ_EN
          spi_csn   <= 1'b1;
          gap_cnt   <= '0;
`endif
        end
        GAP: gap_cnt <= gap_cnt + 16'd1;
`ifdef SPI_FLASH_SEQ_EN
        HOLD: begin
          if (state_next == GAP) begin
            spi_csn <= 1'b1;
            gap_cnt <= '0;
          end else if (state_next == DATA) begin
            live <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (state == IDLE && rd_req) shreg <= {8'h03, mem_addr[23:2], 2'b00};
    else if (fall)               shreg <= {shreg[30:0], 1'b0};
    if (rise && state == DATA) rx[rx_idx] <= spi_miso;
`ifdef SPI_FLASH_SEQ_EN
    if (state == IDLE && rd_req)                         next_word <= mem_addr[23:2] + 22'd1;
    else if (state == HOLD && state_next == DATA)        next_word <= next_word + 22'd1;
`endif
  end

endmodule

// File: tb/tb_spi_flash_rd.sv
// Scoreboard bench for spi_flash_rd: a behavioural SPI flash model feeds MISO; expected words are queued per request.
module tb_spi_flash_rd;
  localparam int DIV     = 2;
  localparam int CS_HIGH = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        spi_csn, spi_sck, spi_mosi, busy;
  logic        spi_miso = 1'b0;

  spi_flash_rd #(.DIV(DIV), .CS_HIGH(CS_HIGH)) dut (
    .CLK100MHZ(clk), .resetn(resetn), .sel(sel), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .spi_csn(spi_csn), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, t_issue = 0;
  typedef struct {logic [31:0] data; int lat;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(posedge clk) cyc++;

  // Flash contents used by the tests; everything else reads as erased.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h100000: return 8'h13;  24'h100001: return 8'h05;
      24'h100002: return 8'h10;  24'h100003: return 8'h00;
      24'h100004: return 8'h93;  24'h100005: return 8'h01;
      24'h100006: return 8'h20;  24'h100007: return 8'h00;
      24'h100040: return 8'hEF;  24'h100041: return 8'hBE;
      24'h100042: return 8'hAD;  24'h100043: return 8'hDE;
      24'h100100: return 8'h11;  24'h100101: return 8'h22;
      24'h100102: return 8'h33;  24'h100103: return 8'h44;
      default:    return 8'hFF;
    endcase
  endfunction

  int          nbits = 0, dcnt = 0, rises = 0, n_cmds = 0, n_falls = 0, n_rise_cs = 0;
  int          t_rise = 0, last_high = 0;
  logic [31:0] sh = '0;
  logic [7:0]  last_cmd = '0, fb;
  logic [23:0] last_addr = '0, rd_addr = '0;

  always @(negedge spi_csn) begin
    nbits = 0; dcnt = 0; rises = 0; n_falls++; last_high = cyc - t_rise;
  end
  always @(posedge spi_csn) begin
    n_rise_cs++; t_rise = cyc;
  end
  always @(posedge spi_sck) begin
    rises++;
    if (nbits < 32) begin
      sh = {sh[30:0], spi_mosi};
      nbits++;
      if (nbits == 32) begin
        last_cmd = sh[31:24]; last_addr = sh[23:0]; rd_addr = sh[23:0]; n_cmds++;
      end
    end
  end
  always @(negedge spi_sck) begin
    if (nbits >= 32) begin
      fb = flash_byte(rd_addr + 24'(dcnt / 8));
      spi_miso = fb[3'(7 - dcnt % 8)];
      dcnt++;
    end
  end

  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready got rdata=%h required no ready", mem_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_rdata !== mon_e.data) begin
          failures++;
          $display("FAIL rdata got=%h required=%h", mem_rdata, mon_e.data);
        end
        if (mon_e.lat >= 0) begin
          checks++;
          if (cyc - t_issue != mon_e.lat) begin
            failures++;
            $display("FAIL latency got=%0d required=%0d", cyc - t_issue, mon_e.lat);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic start_req(input logic [31:0] a, input logic [3:0] ws, input logic s);
    @(negedge clk);
    mem_addr = a; mem_wstrb = ws; sel = s; mem_valid = 1'b1;
    t_issue = cyc + 1;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_ready !== 1'b1 && n < budget);
    if (mem_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s timeout got no mem_ready required within %0d cycles", name, budget);
      exp_q.delete();
    end
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] d, input int lat);
    exp_q.push_back('{d, lat});
    start_req(a, 4'b0000, 1'b1);
    wait_ready(name, 600);
  endtask

  int f0, c0, r0;

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_csn", 32'(spi_csn), 32'd1);
    chk("reset_sck", 32'(spi_sck), 32'd0);
    chk("reset_ready", 32'(mem_ready), 32'd0);
    chk("reset_rdata", mem_rdata, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    f0 = n_falls;
    exp_q.push_back('{32'h0, 0});
    start_req(32'h0010_0000, 4'b1111, 1'b1);
    wait_ready("write", 20);
    repeat (3) @(negedge clk);
    chk("write_no_cs", 32'(n_falls), 32'(f0));
    chk("write_csn", 32'(spi_csn), 32'd1);

    do_read("read0", 32'h0010_0000, 32'h0010_0513, 2 + 128 * DIV);
    chk("read0_cmd", 32'(last_cmd), 32'h03);
    chk("read0_addr", 32'(last_addr), 32'h10_0000);
    chk("read0_rises", 32'(rises), 32'd64);

    repeat (20) @(negedge clk);
    f0 = n_falls;
    start_req(32'h0010_0000, 4'b0000, 1'b0);
    repeat (300) @(negedge clk);
    mem_valid = 1'b0; sel = 1'b1;
    chk("sel_low_no_cs", 32'(n_falls), 32'(f0));

    c0 = n_cmds;
    start_req(32'h0010_0040, 4'b0000, 1'b1);
    repeat (20) @(negedge clk);
    mem_valid = 1'b0;
    repeat (300) @(negedge clk);
    chk("drop_cmd_issued", 32'(n_cmds), 32'(c0 + 1));
    chk("drop_rises", 32'(rises), 32'd64);
`ifdef SPI_FLASH_SEQ_EN
    chk("drop_busy_hold", 32'(busy), 32'd1);
`else
    chk("drop_csn", 32'(spi_csn), 32'd1);
    chk("drop_busy", 32'(busy), 32'd0);
`endif

    repeat (20) @(negedge clk);
    start_req(32'h0010_0000, 4'b0000, 1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0; mem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_csn", 32'(spi_csn), 32'd1);
    chk("rst_mid_sck", 32'(spi_sck), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    do_read("read4", 32'h0010_0004, 32'h0020_0193, 2 + 128 * DIV);
    chk("read4_addr", 32'(last_addr), 32'h10_0004);

    repeat (20) @(negedge clk);
    do_read("b2b_a", 32'h0010_0000, 32'h0010_0513, -1);
    do_read("b2b_b", 32'h0010_0040, 32'hDEAD_BEEF, -1);
    chk("b2b_cs_gap", 32'(last_high >= CS_HIGH), 32'd1);
    chk("b2b_addr", 32'(last_addr), 32'h10_0040);

`ifdef SPI_FLASH_SEQ_EN
    repeat (20) @(negedge clk);
    do_read("seq_a", 32'h0010_0000, 32'h0010_0513, -1);
    c0 = n_cmds; r0 = n_rise_cs;
    repeat (3) @(negedge clk);
    do_read("seq_b", 32'h0010_0004, 32'h0020_0193, 2 + 64 * DIV);
    chk("seq_no_cmd", 32'(n_cmds), 32'(c0));
    chk("seq_cs_low", 32'(n_rise_cs), 32'(r0));
    chk("seq_rises", 32'(rises), 32'd96);
    do_read("seq_c", 32'h0010_0100, 32'h4433_2211, -1);
    chk("seq_c_cmd_count", 32'(n_cmds), 32'(c0 + 1));
    chk("seq_c_cmd", 32'(last_cmd), 32'h03);
    chk("seq_c_addr", 32'(last_addr), 32'h10_0100);
    chk("seq_c_cs_rise", 32'(n_rise_cs), 32'(r0 + 1));
`endif

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion required finish within 1ms");
    $fatal(1, "watchdog");
  end
endmodule
